alu_req_arbiter: RTL and testbench

- Shares one registered 64-bit ALU between two requesters, ports 0 and 1, using round-robin arbitration.
- The ALU has one cycle of latency: it samples its inputs on a clock edge and its output is valid after that edge.
- For each requester, the block accepts an operation over a valid/ready handshake, drives the ALU, captures the result, and holds it in a per-requester response buffer until that requester accepts it.

---
 rtl/alu_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered, one-cycle-latency ALU between two requesters.
// Optional ALU_OP_CHECK_EN: illegal opcodes (>9) are answered immediately with an error response.
module alu_req_arbiter #(
  parameter int DATA_W  = 64,
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [SHAMT_W-1:0] req0_shift,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [SHAMT_W-1:0] req1_shift,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_data,
  output logic               rsp0_err,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_data,
  output logic               rsp1_err,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic [SHAMT_W-1:0] alu_shift,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;

  state_t              state_q;
  logic                last_q;
  logic                owner_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [SHAMT_W-1:0]  alu_shift_q;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q [2];

  logic [1:0]          elig;
  logic                grant_any, grant_sel, illegal, issue;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [OP_W-1:0]     sel_op;
  logic [SHAMT_W-1:0]  sel_shift;

  // Eligibility looks at the registered buffer state, so a same-cycle drain does not re-open the port.
  assign elig      = {req1_valid & ~rsp_valid_q[1], req0_valid & ~rsp_valid_q[0]};
  assign grant_any = (state_q == IDLE) && (elig != 2'b00);
  assign grant_sel = (&elig) ? ~last_q : elig[1];

  assign sel_a     = grant_sel ? req1_a     : req0_a;
  assign sel_b     = grant_sel ? req1_b     : req0_b;
  assign sel_op    = grant_sel ? req1_op    : req0_op;
  assign sel_shift = grant_sel ? req1_shift : req0_shift;

`ifdef ALU_OP_CHECK_EN
  assign illegal = (sel_op > OP_W'(9));
`else
  assign illegal = 1'b0;
`endif
  assign issue = grant_any & ~illegal;

  assign rsp_valid_d = rsp_valid_q & ~{rsp1_ready, rsp0_ready};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_shift_q <= '0;
      rsp_valid_q <= '0;
      for (int n = 0; n < 2; n++) rsp_data_q[n] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      case (state_q)
        IDLE: begin
          if (grant_any) last_q <= grant_sel;
          if (issue) begin
            alu_a_q     <= sel_a;
            alu_b_q     <= sel_b;
            alu_op_q    <= sel_op;
            alu_shift_q <= sel_shift;
            owner_q     <= grant_sel;
            state_q     <= EXEC;
          end else if (grant_any && illegal) begin
            rsp_valid_q[grant_sel] <= 1'b1;
            rsp_data_q[grant_sel]  <= '0;
          end
        end
        EXEC: state_q <= CAPT;
        CAPT: begin
          // Owner's buffer is known empty here: it could not have been granted otherwise.
          rsp_valid_q[owner_q] <= 1'b1;
          rsp_data_q[owner_q]  <= alu_out;
          state_q              <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_OP_CHECK_EN
  logic [1:0] rsp_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= '0;
    end else if (state_q == IDLE && grant_any && illegal) begin
      rsp_err_q[grant_sel] <= 1'b1;
    end else if (state_q == CAPT) begin
      rsp_err_q[owner_q] <= 1'b0;
    end
  end
  assign rsp0_err = rsp_err_q[0];
  assign rsp1_err = rsp_err_q[1];
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  assign req0_ready = grant_any & ~grant_sel;
  assign req1_ready = grant_any &  grant_sel;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_shift  = alu_shift_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: stub registered ALU, vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [4:0]  req0_shift, req1_shift;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [63:0] rsp0_data, rsp1_data;
  logic [63:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shift;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef ALU_OP_CHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  alu_req_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_shift(req1_shift),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shift(alu_shift),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(logic [63:0] a, logic [63:0] b, logic [3:0] op,
                                         logic [4:0] sh);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a << sh;
      4'd5: return a >> sh;
      4'd6: return ~(a ^ b);
      4'd7: return {63'd0, a == b};
      4'd8: return {63'd0, a < b};
      4'd9: return {63'd0, a > b};
      default: return 64'd0;
    endcase
  endfunction

  // Stub ALU: one cycle of latency, cleared by reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) alu_out <= '0;
    else       alu_out <= alu_fn(alu_a, alu_b, alu_op, alu_shift);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req0_shift = 0;
    req1_a = 0; req1_b = 0; req1_op = 0; req1_shift = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1; #3; reset = 0;
    tick();
  endtask

  task automatic drive(bit port, logic [63:0] a, logic [63:0] b, logic [3:0] op, logic [4:0] sh);
    if (port) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; req1_shift = sh; end
    else      begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; req0_shift = sh; end
  endtask

  // One full transaction on a port; bounded waits on grant and response.
  task automatic serve(bit port, logic [63:0] a, logic [63:0] b, logic [3:0] op, logic [4:0] sh,
                       bit drain, output logic [63:0] d, output logic e);
    bit got = 0;
    drive(port, a, b, op, sh);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      got = port ? req1_ready : req0_ready;
      @(posedge clk);
    end
    #1;
    if (port) req1_valid = 0; else req0_valid = 0;
    chk("serve_grant", {63'd0, got}, 64'd1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = port ? rsp1_valid : rsp0_valid;
      if (!got) tick();
    end
    chk("serve_rsp", {63'd0, got}, 64'd1);
    d = port ? rsp1_data : rsp0_data;
    e = port ? rsp1_err : rsp0_err;
    if (drain) begin
      if (port) rsp1_ready = 1; else rsp0_ready = 1;
      tick();
      rsp0_ready = 0; rsp1_ready = 0;
    end
  endtask

  // Transaction-level reference model.
  int          m_cnt;
  bit          m_last, m_owner;
  bit [1:0]    m_rv;
  logic [63:0] m_rd [2];
  bit          m_re [2];
  logic [63:0] m_res, m_alu_a;
  logic [3:0]  m_alu_op;

  function automatic void model_reset();
    m_cnt = 0; m_last = 1; m_owner = 0; m_rv = 0;
    m_rd[0] = 0; m_rd[1] = 0; m_re[0] = 0; m_re[1] = 0;
    m_alu_a = 0; m_alu_op = 0; m_res = 0;
  endfunction

  task automatic model_cycle();
    bit e0, e1, any, g;
    logic [63:0] a, b;
    logic [3:0] op;
    logic [4:0] sh;
    e0 = req0_valid && !m_rv[0];
    e1 = req1_valid && !m_rv[1];
    any = (m_cnt == 0) && (e0 || e1);
    g = (e0 && e1) ? !m_last : e1;
    chk("rnd_ready0", {63'd0, req0_ready}, {63'd0, any && !g});
    chk("rnd_ready1", {63'd0, req1_ready}, {63'd0, any && g});
    chk("rnd_busy", {63'd0, busy}, {63'd0, m_cnt != 0});
    chk("rnd_rsp0_valid", {63'd0, rsp0_valid}, {63'd0, m_rv[0]});
    chk("rnd_rsp1_valid", {63'd0, rsp1_valid}, {63'd0, m_rv[1]});
    if (m_rv[0]) begin
      chk("rnd_rsp0_data", rsp0_data, m_rd[0]);
      chk("rnd_rsp0_err", {63'd0, rsp0_err}, {63'd0, m_re[0]});
    end
    if (m_rv[1]) begin
      chk("rnd_rsp1_data", rsp1_data, m_rd[1]);
      chk("rnd_rsp1_err", {63'd0, rsp1_err}, {63'd0, m_re[1]});
    end
    chk("rnd_alu_a", alu_a, m_alu_a);
    chk("rnd_alu_op", {60'd0, alu_op}, {60'd0, m_alu_op});
    // Advance the model across the coming clock edge.
    if (m_rv[0] && rsp0_ready) m_rv[0] = 0;
    if (m_rv[1] && rsp1_ready) m_rv[1] = 0;
    if (any) begin
      a = g ? req1_a : req0_a;   b = g ? req1_b : req0_b;
      op = g ? req1_op : req0_op; sh = g ? req1_shift : req0_shift;
      m_last = g;
      if (OPCHK && op > 4'd9) begin
        m_rv[g] = 1; m_rd[g] = 0; m_re[g] = 1;
      end else begin
        m_owner = g; m_res = alu_fn(a, b, op, sh);
        m_alu_a = a; m_alu_op = op; m_cnt = 2;
      end
    end else if (m_cnt == 2) begin
      m_cnt = 1;
    end else if (m_cnt == 1) begin
      m_cnt = 0; m_rv[m_owner] = 1; m_rd[m_owner] = m_res; m_re[m_owner] = 0;
    end
  endtask

  typedef struct {
    bit          port;
    logic [63:0] a, b;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [63:0] d;
    logic        e;
    logic [3:0]  prev_op;

    tbl[0] = '{0, 64'd5, 64'd3, 4'd0, 5'd0, 64'd8};
    tbl[1] = '{1, 64'd10, 64'd4, 4'd1, 5'd0, 64'd6};
    tbl[2] = '{0, 64'hF0F0, 64'h0FF0, 4'd2, 5'd0, 64'h00F0};
    tbl[3] = '{1, 64'hF000, 64'h000F, 4'd3, 5'd0, 64'hF00F};
    tbl[4] = '{0, 64'd1, 64'd8, 4'd4, 5'd8, 64'd256};
    tbl[5] = '{1, 64'h8000_0000_0000_0000, 64'd0, 4'd5, 5'd31, 64'h0000_0001_0000_0000};
    tbl[6] = '{0, 64'hFFFF_FFFF_0000_0000, 64'd0, 4'd6, 5'd0, 64'h0000_0000_FFFF_FFFF};
    tbl[7] = '{1, 64'd7, 64'd7, 4'd7, 5'd0, 64'd1};
    tbl[8] = '{0, 64'd2, 64'd9, 4'd8, 5'd0, 64'd1};
    tbl[9] = '{0, 64'd2, 64'd9, 4'd9, 5'd0, 64'd0};

    reset = 1;
    idle_inputs();
    #12 reset = 0;
    tick();

    // Reset state and single-op latency.
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
    chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
    chk("rst_rsp0_data", rsp0_data, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
    drive(0, 64'd5, 64'd3, 4'd0, 5'd0);
    #1;
    chk("lat_ready0", {63'd0, req0_ready}, 64'd1);
    chk("lat_ready1", {63'd0, req1_ready}, 64'd0);
    tick();
    req0_valid = 0;
    #1;
    chk("lat_exec_busy", {63'd0, busy}, 64'd1);
    chk("lat_exec_ready0", {63'd0, req0_ready}, 64'd0);
    chk("lat_alu_a", alu_a, 64'd5);
    tick();
    chk("lat_capt_busy", {63'd0, busy}, 64'd1);
    chk("lat_capt_rsp0", {63'd0, rsp0_valid}, 64'd0);
    tick();
    chk("lat_done_busy", {63'd0, busy}, 64'd0);
    chk("lat_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    chk("lat_rsp0_data", rsp0_data, 64'd8);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    chk("lat_drained", {63'd0, rsp0_valid}, 64'd0);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      serve(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sh, 1, d, e);
      chk($sformatf("vec%0d_data", i), d, tbl[i].exp);
      chk($sformatf("vec%0d_err", i), {63'd0, e}, 64'd0);
    end

    // Simultaneous requests: port 0 wins the first tie after reset.
    do_reset();
    drive(0, 64'd10, 64'd4, 4'd1, 5'd0);
    drive(1, 64'd1, 64'd8, 4'd4, 5'd8);
    #1;
    chk("tie1_ready0", {63'd0, req0_ready}, 64'd1);
    chk("tie1_ready1", {63'd0, req1_ready}, 64'd0);
    tick();
    req0_valid = 0;
    tick(); tick();
    chk("tie1_rsp0_data", rsp0_data, 64'd6);
    chk("tie1_ready1_next", {63'd0, req1_ready}, 64'd1);
    tick();
    req1_valid = 0;
    tick(); tick();
    chk("tie1_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    chk("tie1_rsp1_data", rsp1_data, 64'd256);
    rsp0_ready = 1; rsp1_ready = 1;
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
    serve(0, 64'd1, 64'd1, 4'd0, 5'd0, 1, d, e);
    drive(0, 64'd3, 64'd1, 4'd0, 5'd0);
    drive(1, 64'd3, 64'd1, 4'd1, 5'd0);
    #1;
    chk("tie2_ready1", {63'd0, req1_ready}, 64'd1);
    chk("tie2_ready0", {63'd0, req0_ready}, 64'd0);
    tick();
    req1_valid = 0;
    tick(); tick();
    chk("tie2_rsp1_data", rsp1_data, 64'd2);
    tick();
    req0_valid = 0;
    tick(); tick();
    chk("tie2_rsp0_data", rsp0_data, 64'd4);
    rsp0_ready = 1; rsp1_ready = 1;
    tick();
    rsp0_ready = 0; rsp1_ready = 0;

    // Full response buffer blocks its port; same-edge drain does not re-open it.
    do_reset();
    serve(0, 64'd1, 64'd1, 4'd0, 5'd0, 0, d, e);
    drive(0, 64'd20, 64'd22, 4'd0, 5'd0);
    drive(1, 64'd7, 64'd7, 4'd7, 5'd0);
    #1;
    chk("blk_ready0", {63'd0, req0_ready}, 64'd0);
    chk("blk_ready1", {63'd0, req1_ready}, 64'd1);
    tick();
    req1_valid = 0;
    tick(); tick();
    chk("blk_rsp1_data", rsp1_data, 64'd1);
    chk("blk_rsp0_stable", rsp0_data, 64'd2);
    chk("blk_ready0_idle", {63'd0, req0_ready}, 64'd0);
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    chk("blk_same_edge", {63'd0, req0_ready}, 64'd0);
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk("blk_rsp0_fell", {63'd0, rsp0_valid}, 64'd0);
    chk("blk_rsp1_fell", {63'd0, rsp1_valid}, 64'd0);
    chk("blk_regrant", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 0;
    tick(); tick();
    chk("blk_rsp0_new", rsp0_data, 64'd42);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;

    // Reset during EXEC discards the operation.
    drive(1, 64'd9, 64'd9, 4'd0, 5'd0);
    tick();
    req1_valid = 0;
    #1;
    chk("rx_in_exec", {63'd0, busy}, 64'd1);
    reset = 1; #2; reset = 0; #1;
    chk("rx_busy", {63'd0, busy}, 64'd0);
    chk("rx_alu_a", alu_a, 64'd0);
    chk("rx_alu_op", {60'd0, alu_op}, 64'd0);
    tick(); tick(); tick();
    chk("rx_no_rsp1", {63'd0, rsp1_valid}, 64'd0);
    chk("rx_no_rsp0", {63'd0, rsp0_valid}, 64'd0);
    serve(1, 64'd100, 64'd1, 4'd1, 5'd0, 1, d, e);
    chk("rx_after_data", d, 64'd99);

    // Opcode beyond the legal range.
    prev_op = alu_op;
    drive(1, 64'd3, 64'd4, 4'd12, 5'd0);
    #1;
    chk("ill_ready1", {63'd0, req1_ready}, 64'd1);
    tick();
    req1_valid = 0;
`ifdef ALU_OP_CHECK_EN
    chk("ill_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    chk("ill_rsp1_err", {63'd0, rsp1_err}, 64'd1);
    chk("ill_rsp1_data", rsp1_data, 64'd0);
    chk("ill_alu_op", {60'd0, alu_op}, {60'd0, prev_op});
    chk("ill_busy", {63'd0, busy}, 64'd0);
`else
    tick();
    chk("ill_rsp1_early", {63'd0, rsp1_valid}, 64'd0);
    tick();
    chk("ill_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    chk("ill_rsp1_err", {63'd0, rsp1_err}, 64'd0);
    chk("ill_rsp1_data", rsp1_data, 64'd0);
    chk("ill_alu_op", {60'd0, alu_op}, 64'd12);
`endif
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      req0_op = 4'($urandom_range(0, 11)); req1_op = 4'($urandom_range(0, 11));
      req0_shift = 5'($urandom); req1_shift = 5'($urandom);
      rsp0_ready = ($urandom_range(0, 1) == 1);
      rsp1_ready = ($urandom_range(0, 1) == 1);
      #1;
      model_cycle();
      tick();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
